// File: rtl/z80_pin_pkg.sv
// Shared phase encoding and pin/strobe bit positions for the Z80 pin sequencer.
package z80_pin_pkg;

    // Each name says what uo_out carries while that phase is current.
    typedef enum logic [1:0] {
        PH_ALO  = 2'd1,
        PH_AHI  = 2'd2,
        PH_CTL  = 2'd3,
        PH_SNAP = 2'd0
    } phase_t;

    localparam int CTRL_M1    = 0;
    localparam int CTRL_MREQ  = 1;
    localparam int CTRL_IORQ  = 2;
    localparam int CTRL_RD    = 3;
    localparam int CTRL_WR    = 4;
    localparam int CTRL_RFSH  = 5;
    localparam int CTRL_HALT  = 6;
    localparam int CTRL_BUSAK = 7;

    localparam int UI_WAIT  = 0;
    localparam int UI_INT   = 1;
    localparam int UI_NMI   = 2;
    localparam int UI_BUSRQ = 3;
    localparam int UI_RESET = 4;

    localparam logic [7:0] CTRL_RESET = 8'hFF;

endpackage

// File: rtl/z80_reset_stretch.sv
// Holds the core in reset for RST_HOLD T-states after rst_n or a sampled external reset.
module z80_reset_stretch #(
    parameter int RST_HOLD = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic cen,
    input  logic load,
    output logic cpu_reset_n
);
    import z80_pin_pkg::*;

    localparam int W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [W-1:0] HOLD = W'(RST_HOLD);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_d;

    // Load wins over decrement so a held external reset keeps the count pinned.
    always_comb begin
        cnt_d = cnt;
        if (ena) begin
            if (load) begin
                cnt_d = HOLD;
            end else if (cen && (cnt != '0)) begin
                cnt_d = cnt - 1'b1;
            end
        end
    end

    // Registering from the next count lets reset release on the final cen edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= HOLD;
            cpu_reset_n <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            cpu_reset_n <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/z80_pin_sequencer.sv
// Multiplexes the Z80 core bus onto the TinyTapeout pins over a four-clock T-state
// and paces the core with a one-clock enable per T-state.
module z80_pin_sequencer #(
    parameter int RST_HOLD = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic        cpu_cen,
    output logic        cpu_reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  cpu_ctrl_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    output logic        cpu_int_n,
    output logic        cpu_nmi_n,
    output logic        cpu_busrq_n
);
    import z80_pin_pkg::*;

    phase_t      ph;
    phase_t      ph_d;
    logic [15:0] snap_addr;
    logic [7:0]  snap_dout;
    logic [7:0]  snap_ctrl;
    logic        ext_reset_n;
    logic        unused_ui;

    assign unused_ui = &{1'b0, ui_in[7:5]};

    always_comb begin
        ph_d = ph;
        if (ena) begin
            case (ph)
                PH_SNAP: ph_d = PH_ALO;
                PH_ALO:  ph_d = PH_AHI;
                PH_AHI:  ph_d = PH_CTL;
                PH_CTL:  ph_d = PH_SNAP;
                default: ph_d = PH_SNAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= PH_SNAP;
        end else begin
            ph <= ph_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_addr   <= 16'h0000;
            snap_dout   <= 8'h00;
            snap_ctrl   <= CTRL_RESET;
            uo_out      <= 8'hFF;
            cpu_din     <= 8'h00;
            cpu_wait_n  <= 1'b1;
            cpu_int_n   <= 1'b1;
            cpu_nmi_n   <= 1'b1;
            cpu_busrq_n <= 1'b1;
            ext_reset_n <= 1'b1;
        end else if (ena) begin
            case (ph)
                PH_SNAP: begin
                    snap_addr <= cpu_addr;
                    snap_dout <= cpu_dout;
                    snap_ctrl <= cpu_ctrl_n;
                    // Same value the snapshot is taking on this edge.
                    uo_out    <= cpu_addr[7:0];
                end
                PH_ALO: uo_out <= snap_addr[15:8];
                PH_AHI: uo_out <= snap_ctrl;
                PH_CTL: begin
                    uo_out <= snap_ctrl;
                    if (!snap_ctrl[CTRL_RD]) begin
                        cpu_din <= uio_in;
                    end
                    cpu_wait_n  <= ui_in[UI_WAIT];
                    cpu_int_n   <= ui_in[UI_INT];
                    cpu_nmi_n   <= ui_in[UI_NMI];
                    cpu_busrq_n <= ui_in[UI_BUSRQ];
                    ext_reset_n <= ui_in[UI_RESET];
                end
                default: uo_out <= snap_ctrl;
            endcase
        end
    end

    assign uio_out = snap_dout;
    // ph0/ph1 leave the bus undriven so board and core can turn it around.
    assign uio_oe  = (ena && (ph == PH_AHI || ph == PH_CTL) && !snap_ctrl[CTRL_WR]) ? 8'hFF : 8'h00;
    assign cpu_cen = ena && (ph == PH_CTL);

    z80_reset_stretch #(
        .RST_HOLD(RST_HOLD)
    ) u_reset_stretch (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cen        (cpu_cen),
        .load       (!ext_reset_n),
        .cpu_reset_n(cpu_reset_n)
    );

endmodule

// File: doc/z80_pin_sequencer.md
# z80_pin_sequencer

Time-multiplexes the Z80 core's 16-bit address, 8 control strobes and bidirectional data bus onto the 24 TinyTapeout pins, and paces the core with a clock enable. It sits between the top-level pin wrapper (`ui_in`/`uo_out`/`uio_*`) and the Z80 core. It also:
- samples external control inputs once per core T-state;
- stretches core reset for a fixed number of T-states.

One core T-state equals four system clocks.

## Interface
Parameters:
- `RST_HOLD`, default 3: number of core T-states for which `cpu_reset_n` is held low after any reset source.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  design selected; when low, sequencer freezes
- `ui_in`  in  8  [0] wait_n, [1] int_n, [2] nmi_n, [3] busrq_n, [4] ext reset_n, [7:5] unused
- `uo_out`  out  8  multiplexed address/control byte
- `uio_in`  in  8  data bus from board
- `uio_out`  out  8  data bus to board
- `uio_oe`  out  8  data bus direction, 0xFF drive / 0x00 input
- `cpu_cen`  out  1  core clock enable, one-clock pulse per T-state
- `cpu_reset_n`  out  1  core reset, active low
- `cpu_addr`  in  16  core address
- `cpu_dout`  in  8  core write data
- `cpu_ctrl_n`  in  8  [0] m1, [1] mreq, [2] iorq, [3] rd, [4] wr, [5] rfsh, [6] halt, [7] busak (all active low)
- `cpu_din`  out  8  read data to core
- `cpu_wait_n`, `cpu_int_n`, `cpu_nmi_n`, `cpu_busrq_n`  out  1 each  sampled inputs to core

## Operation
- 2-bit phase counter `ph` cycles 0→1→2→3→0 on each clock with `ena`=1; it holds when `ena`=0.
- Snapshot register: captures `cpu_addr`, `cpu_dout`, `cpu_ctrl_n` on the edge ending ph0, when the core outputs have settled after the previous `cpu_cen`.
- `uo_out` is registered and loaded for the upcoming phase:
  - ph1: snap addr[7:0]
  - ph2: snap addr[15:8]
  - ph3 and ph0: snap ctrl byte
- `uio_out` = snap dout, valid from ph1 onward.
- `uio_oe` = 0xFF during ph2 and ph3 when snap wr_n=0; otherwise 0x00. Bus is released in ph0 and ph1 for turnaround.
- Edge ending ph3:
  - `cpu_din` ← `uio_in` if snap rd_n=0, else `cpu_din` holds.
  - `ui_in[3:0]` → `cpu_wait_n`/`cpu_int_n`/`cpu_nmi_n`/`cpu_busrq_n`.
  - `ui_in[4]` → ext-reset flag.
- `cpu_cen` = (ph==3) && `ena`, combinational from registered state. The core advances on that edge.
- Reset stretch: counter loads `RST_HOLD` on `rst_n` assertion, or when sampled ext reset_n=0.
  - Decrements on each `cpu_cen` while nonzero.
  - `cpu_reset_n` = (counter==0), registered.
  - `cpu_cen` keeps pulsing during stretch.
- `ena`=0 mid-cycle:
  - no state changes; `cpu_cen`=0;
  - `uio_oe` forced 0x00 combinationally;
  - all other outputs hold.
  - Resumes at the frozen phase.

## Timing
- Reset values: `ph`=0, `uo_out`=0xFF, `uio_out`=0x00, `uio_oe`=0x00, `cpu_din`=0x00, `cpu_cen`=0, `cpu_reset_n`=0, sampled inputs=1, snapshot ctrl=0xFF, addr/dout=0.
- First clock after `rst_n` release is ph0. First `cpu_cen` occurs in the 4th clock.
- `cpu_reset_n` rises on the edge after the `RST_HOLD`-th `cpu_cen`.
- Address lo/hi are each visible for exactly one clock. Ctrl is visible for two consecutive clocks.
- Latency:
  - core output → pin: 1 clock (snapshot) + 1 clock (output register).
  - pin input → core: sampled at end of ph3, consumed by the core at the next `cpu_cen`.
- Ext reset sampled low while a stretch is already counting restarts the count at `RST_HOLD`.
- `rst_n` asserted mid-phase returns all state to reset values immediately (asynchronous).

## Structure
- Package `z80_pin_pkg`:
  - phase enum (`PH_ALO`…);
  - `CTRL_*` bit indices for `cpu_ctrl_n`;
  - `UI_*` bit indices for `ui_in`;
  - ctrl reset constant 8'hFF.
- Sub-module `z80_reset_stretch`: counter, load/decrement logic and `cpu_reset_n` register, parameterised by `RST_HOLD`.
- Everything else is flat in `z80_pin_sequencer`.

## Test plan
- Reset release → `uo_out`=0xFF, `uio_oe`=0x00. `cpu_cen` pulses at clocks 4, 8, 12. `cpu_reset_n` rises after the 3rd pulse.
- Core drives addr=0x1234, ctrl=0xF5 (mreq, rd low), board drives `uio_in`=0xA5 → `uo_out` sequence 0x34, 0x12, 0xF5, 0xF5. `uio_oe`=0x00 throughout. `cpu_din`=0xA5 after ph3.
- Write: addr=0xBEEF, dout=0x5A, ctrl=0xED (mreq, wr low) → `uio_out`=0x5A. `uio_oe`=0xFF in ph2/ph3 only. `cpu_din` unchanged.
- `ui_in`=0x1C held one full T-state (wait_n=0, int_n=0) → after the ph3 edge, `cpu_wait_n`=0 and `cpu_int_n`=0; `cpu_nmi_n` and `cpu_busrq_n` remain 1.
- `ena` dropped in ph2 of a write for 5 clocks → `ph` frozen, `uio_oe`=0x00, no `cpu_cen`. On re-enable the sequence continues at ph2 with `uio_oe`=0xFF.
- `ui_in[4]`=0 sampled while `cpu_reset_n`=1 → `cpu_reset_n`=0 on the next edge, then returns to 1 after 3 `cpu_cen` pulses once `ui_in[4]`=1.
